// File: rtl/conv_rd_pkg.sv
// Shared types and sizing helpers for the convolution window reader.
package conv_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  function automatic int out_dim_nopad(input int img, input int k, input int stride);
    return (img - k) / stride + 32'sd1;
  endfunction

  function automatic int out_dim_pad(input int img, input int k, input int stride);
    return (img + 32'sd2 - k) / stride + 32'sd1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window position (wr,wc) and in-window index (kr,kc) counters with address generation.
// Optional one-pixel zero padding is selected by the CONV_RD_PAD_EN macro.
module conv_addr_gen
  import conv_rd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int BASE_ADDR = 0,
  localparam int IDX_W    = cnt_w(K * K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pos_clr,
  input  logic              idx_step,
  input  logic              pos_adv,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds,
  output logic [IDX_W-1:0]  idx,
  output logic              last_idx,
  output logic              last_win
);

`ifdef CONV_RD_PAD_EN
  localparam int OUT_W = out_dim_pad(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim_pad(IMG_H, K, STRIDE);
`else
  localparam int OUT_W = out_dim_nopad(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim_nopad(IMG_H, K, STRIDE);
`endif
  localparam int WR_W = cnt_w(OUT_H);
  localparam int WC_W = cnt_w(OUT_W);
  localparam int KI_W = cnt_w(K);
  localparam logic [WR_W-1:0] WR_LAST = WR_W'(OUT_H - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(OUT_W - 1);
  localparam logic [KI_W-1:0] KI_LAST = KI_W'(K - 1);

  logic [WR_W-1:0] wr_q, wr_d, wr_eff_s;
  logic [WC_W-1:0] wc_q, wc_d, wc_eff_s;
  logic [KI_W-1:0] kr_q, kr_d, kc_q, kc_d;
  int              row_s, col_s, addr_s;

  // Position and index counter updates
  always_comb begin
    wr_d = wr_q;
    wc_d = wc_q;
    kr_d = kr_q;
    kc_d = kc_q;
    if (pos_clr) begin
      wr_d = '0;
      wc_d = '0;
    end else if (pos_adv) begin
      if (wc_q == WC_LAST) begin
        wc_d = '0;
        wr_d = (wr_q == WR_LAST) ? '0 : wr_q + 1'b1;
      end else begin
        wc_d = wc_q + 1'b1;
      end
    end else begin
      wr_d = wr_q;
    end
    if (idx_step) begin
      if (kc_q == KI_LAST) begin
        kc_d = '0;
        kr_d = (kr_q == KI_LAST) ? '0 : kr_q + 1'b1;
      end else begin
        kc_d = kc_q + 1'b1;
      end
    end else begin
      kc_d = kc_q;
    end
  end

  // A clear coinciding with a start must address window (0,0) on that same edge
  always_comb begin
    wr_eff_s = pos_clr ? '0 : wr_q;
    wc_eff_s = pos_clr ? '0 : wc_q;
    row_s    = int'(wr_eff_s) * STRIDE + int'(kr_q);
    col_s    = int'(wc_eff_s) * STRIDE + int'(kc_q);
`ifdef CONV_RD_PAD_EN
    row_s     = row_s - 32'sd1;
    col_s     = col_s - 32'sd1;
    in_bounds = (row_s >= 32'sd0) && (row_s < IMG_H) && (col_s >= 32'sd0) && (col_s < IMG_W);
`else
    in_bounds = 1'b1;
`endif
    addr_s   = BASE_ADDR + row_s * IMG_W + col_s;
    addr     = ADDR_W'(addr_s);
    idx      = IDX_W'(int'(kr_q) * K + int'(kc_q));
    last_idx = (kr_q == KI_LAST) && (kc_q == KI_LAST);
    last_win = (wr_q == WR_LAST) && (wc_q == WC_LAST);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      wc_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
    end else begin
      wr_q <= wr_d;
      wc_q <= wc_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
    end
  end

endmodule

// File: rtl/conv_win_reader.sv
// Fetches one KxK window per start/done handshake from a synchronous-read memory.
// Define CONV_RD_PAD_EN for one-pixel zero padding around the feature map.
module conv_win_reader
  import conv_rd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clr,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [K*K*DATA_W-1:0] win_flat,
  output logic                  last_win
);

  localparam int IDX_W = cnt_w(K * K);

  rd_state_t               state_q, state_d;
  logic                    done_q, done_d, rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [K*K*DATA_W-1:0]   win_q, win_d;
  logic                    iss_act_q, iss_act_d, iss_zero_q, iss_zero_d, iss_last_q, iss_last_d;
  logic [IDX_W-1:0]        iss_idx_q, iss_idx_d, cap_idx_q, cap_idx_d;
  logic                    cap_act_q, cap_act_d, cap_zero_q, cap_zero_d;
  logic                    issue_s, pos_clr_s, idx_step_s, pos_adv_s;
  logic [ADDR_W-1:0]       gen_addr_s;
  logic                    gen_inb_s, gen_last_idx_s;
  logic [IDX_W-1:0]        gen_idx_s;

  conv_addr_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .K(K), .STRIDE(STRIDE), .BASE_ADDR(BASE_ADDR)
  ) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .pos_clr(pos_clr_s), .idx_step(idx_step_s),
    .pos_adv(pos_adv_s), .addr(gen_addr_s), .in_bounds(gen_inb_s),
    .idx(gen_idx_s), .last_idx(gen_last_idx_s), .last_win(last_win)
  );

  // Handshake FSM; each issued index rides an issue->capture pipe matching memory latency
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    iss_act_d  = 1'b0;
    iss_zero_d = 1'b0;
    iss_last_d = 1'b0;
    iss_idx_d  = iss_idx_q;
    cap_act_d  = iss_act_q;
    cap_zero_d = iss_zero_q;
    cap_idx_d  = iss_idx_q;
    issue_s    = 1'b0;
    pos_clr_s  = 1'b0;
    idx_step_s = 1'b0;
    pos_adv_s  = 1'b0;
    win_d      = win_q;
    case (state_q)
      ST_IDLE: begin
        pos_clr_s = clr;
        if (start) begin
          issue_s = 1'b1;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (iss_last_q) begin
          state_d = ST_DRAIN;
        end else begin
          issue_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        if (!start) begin
          done_d    = 1'b0;
          pos_adv_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
    if (issue_s) begin
      idx_step_s = 1'b1;
      iss_act_d  = 1'b1;
      iss_idx_d  = gen_idx_s;
      iss_last_d = gen_last_idx_s;
      iss_zero_d = !gen_inb_s;
      rd_en_d    = gen_inb_s;
      addr_d     = gen_inb_s ? gen_addr_s : addr_q;
    end else begin
      addr_d = addr_q;
    end
    if (cap_act_q) begin
      win_d[int'(cap_idx_q)*DATA_W +: DATA_W] = cap_zero_q ? '0 : mem_rdata;
    end else begin
      win_d = win_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      win_q      <= '0;
      iss_act_q  <= 1'b0;
      iss_zero_q <= 1'b0;
      iss_last_q <= 1'b0;
      iss_idx_q  <= '0;
      cap_act_q  <= 1'b0;
      cap_zero_q <= 1'b0;
      cap_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      win_q      <= win_d;
      iss_act_q  <= iss_act_d;
      iss_zero_q <= iss_zero_d;
      iss_last_q <= iss_last_d;
      iss_idx_q  <= iss_idx_d;
      cap_act_q  <= cap_act_d;
      cap_zero_q <= cap_zero_d;
      cap_idx_q  <= cap_idx_d;
    end
  end

  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign win_flat  = win_q;

endmodule

// File: tb/tb_conv_win_reader.sv
// Self-checking bench for conv_win_reader against a raster-order window model.
module tb_conv_win_reader;

  localparam int DATA_W = 8, ADDR_W = 10, IMG_W = 4, IMG_H = 4, K = 3, STRIDE = 1, BASE_ADDR = 0;
`ifdef CONV_RD_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int OUT_W = (IMG_W + 2 * PAD - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H + 2 * PAD - K) / STRIDE + 1;
  localparam int KK = K * K;
  localparam int WW = KK * DATA_W;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
  logic done, mem_rd_en, last_win;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [WW-1:0] win_flat;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int n_vec = 0, n_err = 0;
  int m_r = 0, m_c = 0;
  int exp_addr[$], got_addr[$];
  logic [WW-1:0] exp_win, win_got;
  int n_rd, done_lat, done_len, rd_after;
  bit fetch_ok, lw_before;

  conv_win_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .K(K), .STRIDE(STRIDE), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .win_flat(win_flat), .last_win(last_win)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data valid the cycle after the address is sampled
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic fill_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
  endtask

  // Expected reads and window contents for window (r,c), straight from the addressing rule
  task automatic build_exp(input int r, input int c);
    exp_addr.delete();
    exp_win = '0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++) begin
        int row, col, a;
        row = r * STRIDE + kr - PAD;
        col = c * STRIDE + kc - PAD;
        if (row >= 0 && row < IMG_H && col >= 0 && col < IMG_W) begin
          a = (BASE_ADDR + row * IMG_W + col) % (1 << ADDR_W);
          exp_addr.push_back(a);
          exp_win[(kr * K + kc) * DATA_W +: DATA_W] = mem[a];
        end
      end
  endtask

  task automatic model_adv();
    m_c++;
    if (m_c == OUT_W) begin
      m_c = 0;
      m_r++;
      if (m_r == OUT_H) m_r = 0;
    end
  endtask

  // One handshake; records what the DUT did, sampled on falling edges
  task automatic fetch(input int drop_at, input int hold_extra, input int clr_at, input bit clr_start);
    got_addr.delete();
    n_rd = 0; done_lat = -1; done_len = 0; rd_after = 0; fetch_ok = 0;
    @(negedge clk);
    lw_before = last_win;
    start = 1'b1;
    clr = clr_start;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      clr = (c == clr_at);
      if (c == drop_at) start = 1'b0;
      if (mem_rd_en) begin
        if (done_lat < 0) begin
          n_rd++;
          got_addr.push_back(int'(mem_addr));
        end else rd_after++;
      end
      if (done) begin
        if (done_lat < 0) begin
          done_lat = c - 1;
          win_got = win_flat;
        end
        done_len++;
        if (done_len > hold_extra) start = 1'b0;
      end else if (done_lat >= 0) begin
        fetch_ok = 1;
        break;
      end
    end
    start = 1'b0;
    clr = 1'b0;
    n_vec++;
    if (!fetch_ok) begin
      n_err++;
      $display("FAIL handshake_timeout: done_lat=%0d done_len=%0d, required a completed handshake", done_lat, done_len);
    end
  endtask

  task automatic test_reset();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    n_vec++; if (win_flat !== '0) begin n_err++; $display("FAIL reset_win: got %h want 0", win_flat); end
    n_vec++; if (last_win !== ((OUT_W == 1 && OUT_H == 1) ? 1'b1 : 1'b0)) begin
      n_err++; $display("FAIL reset_last_win: got %b", last_win); end
  endtask

  // Every window of the map in raster order, plus one more to see the wrap to (0,0)
  task automatic test_raster();
`ifdef CONV_RD_PAD_EN
    int lit[$] = '{0, 1, 4, 5};
`else
    int lit[$] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
`endif
    for (int w = 0; w <= OUT_W * OUT_H; w++) begin
      bit exp_lw;
      fill_mem();
      build_exp(m_r, m_c);
      exp_lw = (m_r == OUT_H - 1 && m_c == OUT_W - 1);
      fetch(0, 0, 0, 0);
      n_vec++; if (lw_before !== exp_lw) begin n_err++; $display("FAIL raster_last_win w=%0d: got %b want %b", w, lw_before, exp_lw); end
      n_vec++; if (done_lat != KK + 1) begin n_err++; $display("FAIL raster_done_latency w=%0d: got %0d want %0d", w, done_lat, KK + 1); end
      n_vec++; if (done_len != 1) begin n_err++; $display("FAIL raster_done_len w=%0d: got %0d want 1", w, done_len); end
      n_vec++; if (n_rd != exp_addr.size()) begin n_err++; $display("FAIL raster_nreads w=%0d: got %0d want %0d", w, n_rd, exp_addr.size()); end
      else for (int i = 0; i < n_rd; i++) begin
        n_vec++; if (got_addr[i] != exp_addr[i]) begin n_err++; $display("FAIL raster_addr w=%0d i=%0d: got %0d want %0d", w, i, got_addr[i], exp_addr[i]); end
      end
      n_vec++; if (win_got !== exp_win) begin n_err++; $display("FAIL raster_win w=%0d: got %h want %h", w, win_got, exp_win); end
      if (w == 0 || w == OUT_W * OUT_H) begin
        n_vec++; if (got_addr != lit) begin n_err++; $display("FAIL raster_origin_addrs w=%0d: got %p want %p", w, got_addr, lit); end
      end
      model_adv();
    end
  endtask

  task automatic test_hold_done();
    fill_mem();
    build_exp(m_r, m_c);
    fetch(0, 5, 0, 0);
    n_vec++; if (done_len != 6) begin n_err++; $display("FAIL hold_done_len: got %0d want 6", done_len); end
    n_vec++; if (rd_after != 0) begin n_err++; $display("FAIL hold_no_reads: got %0d want 0", rd_after); end
    n_vec++; if (win_got !== exp_win) begin n_err++; $display("FAIL hold_win: got %h want %h", win_got, exp_win); end
    model_adv();
    build_exp(m_r, m_c);
    fetch(0, 0, 0, 0);
    n_vec++; if (got_addr != exp_addr) begin n_err++; $display("FAIL hold_single_advance: got %p want %p", got_addr, exp_addr); end
    model_adv();
  endtask

  task automatic test_drop_early();
    fill_mem();
    build_exp(m_r, m_c);
    fetch(3, 0, 0, 0);
    n_vec++; if (got_addr != exp_addr) begin n_err++; $display("FAIL drop_addrs: got %p want %p", got_addr, exp_addr); end
    n_vec++; if (done_len != 1) begin n_err++; $display("FAIL drop_done_len: got %0d want 1", done_len); end
    n_vec++; if (done_lat != KK + 1) begin n_err++; $display("FAIL drop_done_latency: got %0d want %0d", done_lat, KK + 1); end
    n_vec++; if (win_got !== exp_win) begin n_err++; $display("FAIL drop_win: got %h want %h", win_got, exp_win); end
    model_adv();
    build_exp(m_r, m_c);
    fetch(0, 0, 0, 0);
    n_vec++; if (got_addr != exp_addr) begin n_err++; $display("FAIL drop_advanced: got %p want %p", got_addr, exp_addr); end
    model_adv();
  endtask

  task automatic test_clr();
    m_r = 0; m_c = 0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    fetch(0, 0, 0, 0); model_adv();
    fetch(0, 0, 0, 0); model_adv();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_r = 0; m_c = 0;
    fill_mem();
    build_exp(0, 0);
    fetch(0, 0, 4, 0);
    n_vec++; if (got_addr != exp_addr) begin n_err++; $display("FAIL clr_idle_addrs: got %p want %p", got_addr, exp_addr); end
    n_vec++; if (win_got !== exp_win) begin n_err++; $display("FAIL clr_idle_win: got %h want %h", win_got, exp_win); end
    model_adv();
    build_exp(m_r, m_c);
    fetch(0, 0, 0, 0);
    n_vec++; if (got_addr != exp_addr) begin n_err++; $display("FAIL clr_in_addr_ignored: got %p want %p", got_addr, exp_addr); end
    model_adv();
    m_r = 0; m_c = 0;
    build_exp(0, 0);
    fetch(0, 0, 0, 1);
    n_vec++; if (got_addr != exp_addr) begin n_err++; $display("FAIL clr_with_start: got %p want %p", got_addr, exp_addr); end
    model_adv();
  endtask

  task automatic test_reset_mid();
    fill_mem();
    @(negedge clk); start = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL midrst_rd_en: got %b want 0", mem_rd_en); end
    n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL midrst_addr: got %0d want 0", mem_addr); end
    n_vec++; if (win_flat !== '0) begin n_err++; $display("FAIL midrst_win: got %h want 0", win_flat); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_r = 0; m_c = 0;
    build_exp(0, 0);
    fetch(0, 0, 0, 0);
    n_vec++; if (got_addr != exp_addr) begin n_err++; $display("FAIL midrst_refetch: got %p want %p", got_addr, exp_addr); end
    n_vec++; if (win_got !== exp_win) begin n_err++; $display("FAIL midrst_win_refetch: got %h want %h", win_got, exp_win); end
    model_adv();
  endtask

  initial begin
    fill_mem();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_raster();
    test_hold_done();
    test_drop_early();
    test_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
